input_debounce: RTL and testbench
=================================

INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 240000, the number of consecutive stable synchronized samples required to accept a new level (20 ms at 12 MHz); legal range 2 .. 2^24.
REQ-002 SHALL have parameter INVERT, default 0; when 1, the raw input is inverted before synchronization (active-low push-buttons).
REQ-003 SHALL have port clk  input  1  the single clock; all flops on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port btn_raw  input  1  asynchronous, bouncing button/switch level.
REQ-006 SHALL have port w  output  1  registered debounced level, fed directly to the downstream sequence detector's w input.
REQ-007 SHALL have port rise  output  1  one-cycle pulse on each accepted 0->1 change of w.
REQ-008 SHALL have port fall  output  1  one-cycle pulse on each accepted 1->0 change of w.

Function
REQ-009 SHALL pass btn_raw (after optional INVERT) through a two-flop synchronizer; only the second flop output (s) is used by the FSM.
REQ-010 SHALL implement FSM states LOW, WAIT_HIGH, HIGH, WAIT_LOW, with counter cnt of width max(1, clog2(DEBOUNCE_CYCLES)).
REQ-011 LOW: s=1 -> WAIT_HIGH, cnt<=0; else stay.
REQ-012 WAIT_HIGH: s=0 -> LOW (bounce rejected, w unchanged); s=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH, w<=1, rise<=1; else cnt<=cnt+1.
REQ-013 HIGH: s=0 -> WAIT_LOW, cnt<=0; else stay.
REQ-014 WAIT_LOW: s=1 -> HIGH (bounce rejected); s=0 and cnt==DEBOUNCE_CYCLES-1 -> LOW, w<=0, fall<=1; else cnt<=cnt+1.
REQ-015 Latency: btn_raw stable from before edge 1 -> w changes after clock edge DEBOUNCE_CYCLES+3 (2 sync + 1 entry + DEBOUNCE_CYCLES-1 count + 1 accept).
REQ-016 rise/fall SHALL be high for exactly one cycle, coincident with the cycle w first shows its new value; never both high together.
REQ-017 Any opposite sample during a WAIT state SHALL restart qualification from zero; cnt SHALL never wrap.
REQ-018 Unused state encodings SHALL transition to LOW with w=0.
REQ-019 w SHALL be w = (state==HIGH || state==WAIT_LOW), registered, glitch-free.

Reset
REQ-020 reset_n=0 SHALL immediately force state LOW, cnt=0, both synchronizer flops 0, w=0, rise=0, fall=0, independent of clk.
REQ-021 Reset asserted mid-qualification SHALL discard progress; after release, behaviour is identical to power-up.
REQ-022 With INVERT=1 and button released (btn_raw=1) at reset release, w SHALL stay 0 with no rise/fall pulse.

Configuration
REQ-023 Macro DEBOUNCE_EDGE_PULSE_EN defined: rise/fall generated per REQ-012/014/016.
REQ-024 Macro absent: rise and fall ports SHALL remain and be driven constant 0, with no pulse logic synthesized; w behaviour is unchanged.

Structure
REQ-025 State encodings (2-bit localparams LOW=00, WAIT_HIGH=01, HIGH=10, WAIT_LOW=11) SHALL live in shared include debounce_defs, reused by other button-input blocks.
REQ-026 The synchronizer SHALL be sub-module sync_2ff (clk, reset_n, d, q), reset value 0.

Verification (DEBOUNCE_CYCLES=4, macro defined)
REQ-027 Clean step: btn_raw 0->1 held -> w=1 and rise=1 after edge 7, rise=0 at edge 8.
REQ-028 Bounce: btn_raw 1 for 3 cycles, 0 for 1, then 1 held -> no w change until 7 edges after final rising step.
REQ-029 Release: from w=1, btn_raw->0 held -> w=0 and fall=1 after edge 7; rise stays 0.
REQ-030 Reset mid-WAIT_HIGH: reset_n low at edge 5 of a press -> w=0 immediately; after release with btn_raw=1, w rises 7 edges later.
REQ-031 INVERT=1: btn_raw held 1 -> w=0 forever; btn_raw 0 held -> w=1 after edge 7.
REQ-032 Macro undefined: REQ-027 stimulus -> w timing identical, rise=fall=0 throughout.

Source files
------------

// File: rtl/debounce_defs.sv
// Shared state encodings and sizing helper for the button-input blocks.
package debounce_defs;

  localparam logic [1:0] LOW       = 2'b00;
  localparam logic [1:0] WAIT_HIGH = 2'b01;
  localparam logic [1:0] HIGH      = 2'b10;
  localparam logic [1:0] WAIT_LOW  = 2'b11;

  // Counter width: max(1, clog2(n)), so cnt reaches n-1 without wrapping.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level, resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Synchronizer chain: only q is safe to use downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/input_debounce.sv
// Button/switch debouncer: sync, then qualify DEBOUNCE_CYCLES stable samples.
// Define DEBOUNCE_EDGE_PULSE_EN to generate the rise/fall pulses; otherwise they tie to 0.
module input_debounce
  import debounce_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter bit INVERT          = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic w,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             din_s;
  logic             s_s;
  logic [1:0]       state_r;
  logic [1:0]       next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             w_r;
  logic             w_next_s;

  assign din_s = INVERT ? ~btn_raw : btn_raw;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (din_s),
    .q       (s_s)
  );

  // State, qualification counter and debounced level registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= LOW;
      cnt_r   <= CNT_ZERO;
      w_r     <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
      w_r     <= w_next_s;
    end
  end

  // Next-state logic; any opposite sample in a WAIT state abandons qualification.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      LOW: begin
        if (s_s) begin
          next_state_s = WAIT_HIGH;
          cnt_next_s   = CNT_ZERO;
        end else begin
          next_state_s = LOW;
        end
      end
      WAIT_HIGH: begin
        if (!s_s) begin
          next_state_s = LOW;
        end else if (cnt_r == CNT_LAST) begin
          next_state_s = HIGH;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s_s) begin
          next_state_s = WAIT_LOW;
          cnt_next_s   = CNT_ZERO;
        end else begin
          next_state_s = HIGH;
        end
      end
      WAIT_LOW: begin
        if (s_s) begin
          next_state_s = HIGH;
        end else if (cnt_r == CNT_LAST) begin
          next_state_s = LOW;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        next_state_s = LOW;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // w follows the state the FSM is entering, so it is registered and glitch-free.
  always_comb begin
    w_next_s = (next_state_s == HIGH) || (next_state_s == WAIT_LOW);
  end

  assign w = w_r;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_next_s;
  logic fall_next_s;
  logic rise_r;
  logic fall_r;

  // Pulses fire only on the accepting transition out of a WAIT state.
  always_comb begin
    rise_next_s = (state_r == WAIT_HIGH) && (next_state_s == HIGH);
    fall_next_s = (state_r == WAIT_LOW)  && (next_state_s == LOW);
  end

  // Edge pulse registers, aligned with the first cycle of the new w.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= rise_next_s;
      fall_r <= fall_next_s;
    end
  end

  assign rise = rise_r;
  assign fall = fall_r;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Randomized bench for input_debounce (INVERT=0 and INVERT=1 instances) against a run-length model.
module tb_input_debounce;

  localparam int DC = 4;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic btn_raw;
  logic w0, rise0, fall0;
  logic w1, rise1, fall1;

  int checks = 0;
  int errors = 0;

  // Model: two-sample delay, then w flips once DC+1 consecutive samples disagree with it.
  logic q1 [2];
  logic q2 [2];
  logic exp_w [2];
  logic exp_rise [2];
  logic exp_fall [2];
  int   run [2];

  always #5 clk = ~clk;

  input_debounce #(.DEBOUNCE_CYCLES(DC), .INVERT(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .w(w0), .rise(rise0), .fall(fall0)
  );

  input_debounce #(.DEBOUNCE_CYCLES(DC), .INVERT(1'b1)) dut_inv (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .w(w1), .rise(rise1), .fall(fall1)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      q1[ch] = 1'b0; q2[ch] = 1'b0; exp_w[ch] = 1'b0;
      exp_rise[ch] = 1'b0; exp_fall[ch] = 1'b0; run[ch] = 0;
    end
  endtask

  task automatic check_all();
    check_bit("w", w0, exp_w[0]);
    check_bit("rise", rise0, exp_rise[0]);
    check_bit("fall", fall0, exp_fall[0]);
    check_bit("inv_w", w1, exp_w[1]);
    check_bit("inv_rise", rise1, exp_rise[1]);
    check_bit("inv_fall", fall1, exp_fall[1]);
  endtask

  task automatic step(input logic b);
    logic s;
    logic bi;
    btn_raw = b;
    @(posedge clk);
    for (int ch = 0; ch < 2; ch++) begin
      bi = (ch == 1) ? ~b : b;
      s = q2[ch];
      q2[ch] = q1[ch];
      q1[ch] = bi;
      exp_rise[ch] = 1'b0;
      exp_fall[ch] = 1'b0;
      if (s != exp_w[ch]) run[ch]++;
      else run[ch] = 0;
      if (run[ch] == DC + 1) begin
        exp_w[ch] = s;
        run[ch] = 0;
        if (PULSE) begin
          exp_rise[ch] = s;
          exp_fall[ch] = ~s;
        end
      end
    end
    #1;
    check_all();
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases at a negedge.
  task automatic do_reset(input logic b);
    @(negedge clk);
    btn_raw = b;
    #2 reset_n = 1'b0;
    #1;
    check_bit("rst_w", w0, 1'b0);
    check_bit("rst_rise", rise0, 1'b0);
    check_bit("rst_fall", fall0, 1'b0);
    check_bit("rst_inv_w", w1, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic lvl;
    int   len;
    reset_n = 1'b0;
    btn_raw = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Clean press: w and rise appear after edge 7, rise drops at edge 8.
    for (int i = 0; i < 6; i++) step(1'b1);
    check_bit("clean_w_e6", w0, 1'b0);
    step(1'b1);
    check_bit("clean_w_e7", w0, 1'b1);
    check_bit("clean_rise_e7", rise0, PULSE);
    step(1'b1);
    check_bit("clean_rise_e8", rise0, 1'b0);
    check_bit("inv_held1_w", w1, 1'b0);

    // Release: fall after edge 7, rise stays low.
    for (int i = 0; i < 6; i++) step(1'b0);
    check_bit("rel_w_e6", w0, 1'b1);
    step(1'b0);
    check_bit("rel_w_e7", w0, 1'b0);
    check_bit("rel_fall_e7", fall0, PULSE);
    check_bit("rel_rise_e7", rise0, 1'b0);
    check_bit("inv_held0_w", w1, 1'b1);

    // Bounce: 1,1,1,0 then held 1; w only after 7 edges from the last rising step.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);
    step(1'b0);
    for (int i = 0; i < 6; i++) step(1'b1);
    check_bit("bounce_w_e6", w0, 1'b0);
    step(1'b1);
    check_bit("bounce_w_e7", w0, 1'b1);

    // Reset mid-qualification, then a fresh 7-edge qualification with btn held 1.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1);
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) step(1'b1);
    check_bit("rst_mid_w_e6", w0, 1'b0);
    step(1'b1);
    check_bit("rst_mid_w_e7", w0, 1'b1);

    // Random bouncy segments with occasional resets.
    lvl = 1'b0;
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 49) == 0) do_reset(1'($urandom_range(0, 1)));
      lvl = ~lvl;
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) step(lvl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
